// File: rtl/sol32_dport_pkg.sv
// Shared types and constants for the sol32 data-port responder.
// Optional build macro used by the responder: SOL32_DPORT_TIMEOUT_EN.
package sol32_dport_pkg;

  localparam logic [31:0] USER_BASE_DEFAULT = 32'h0000_8000;
  localparam int unsigned TIMEOUT_DEFAULT   = 64;
  localparam int unsigned DATA_W            = 32;
  localparam int unsigned LANES             = DATA_W / 8;
  localparam int unsigned WADDR_W           = DATA_W - 2;

  typedef enum logic [1:0] {
    W_BYTE = 2'b00,
    W_HALF = 2'b01,
    W_WORD = 2'b10,
    W_RSVD = 2'b11
  } width_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FC_ALIGN    = 2'd0,
    FC_PRIV     = 2'd1,
    FC_TIMEOUT  = 2'd2,
    FC_CONFLICT = 2'd3
  } cause_e;

  // Reserved width or an access that straddles its natural boundary.
  function automatic logic bad_width(input width_e w, input logic [1:0] a);
    logic bad;
    bad = 1'b0;
    unique case (w)
      W_BYTE:  bad = 1'b0;
      W_HALF:  bad = a[0];
      W_WORD:  bad = (a != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/sol32_lane_align.sv
// Byte-lane steering between a right-justified core datum and a 32-bit word.
// Ports:
//   width_i  access width
//   addr_i   byte offset within the word
//   wdata_i  right-justified store data
//   rdata_i  raw memory word
//   be_o     active byte lanes (0 for reserved width)
//   wdata_o  store data replicated across lanes
//   rdata_o  selected lanes, right-justified and zero-extended
module sol32_lane_align
  import sol32_dport_pkg::*;
(
  input  width_e             width_i,
  input  logic [1:0]         addr_i,
  input  logic [DATA_W-1:0]  wdata_i,
  input  logic [DATA_W-1:0]  rdata_i,
  output logic [LANES-1:0]   be_o,
  output logic [DATA_W-1:0]  wdata_o,
  output logic [DATA_W-1:0]  rdata_o
);

  logic [DATA_W-1:0] shifted;

  assign shifted = rdata_i >> {addr_i, 3'b000};

  // Lane selection per width.
  always_comb begin
    be_o    = '0;
    wdata_o = '0;
    rdata_o = '0;
    unique case (width_i)
      W_BYTE: begin
        be_o    = 4'b0001 << addr_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {24'h0, shifted[7:0]};
      end
      W_HALF: begin
        be_o    = 4'b0011 << {addr_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {16'h0, shifted[15:0]};
      end
      W_WORD: begin
        be_o    = 4'hF;
        wdata_o = wdata_i;
        rdata_o = shifted;
      end
      default: begin
        be_o    = '0;
        wdata_o = '0;
        rdata_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/sol32_data_responder.sv
// Memory-side responder for the sol32 data port: checks a load/store request,
// issues one word access with byte enables, stalls the core until the memory
// completes, and returns lane-aligned load data or a one-cycle fault.
// Optional macro SOL32_DPORT_TIMEOUT_EN adds a WAIT-state timeout (cause 2).
// Ports:
//   Clock, Reset            clock, async active-low reset
//   Mode                    1=user, 0=supervisor
//   ReadEnable/WriteEnable  core load/store request
//   DataWidth               00 byte, 01 half, 10 word, 11 reserved
//   MemoryAddress, DataOut  core byte address and store data
//   DataIn                  load data (valid in the retire cycle)
//   Stall                   combinational hold to the core
//   Fault, FaultCause       one-cycle rejection pulse and reason
//   MemRequest..MemWriteData  word access to memory (strobe is combinational)
//   MemReadData, MemValid   memory completion
module sol32_data_responder
  import sol32_dport_pkg::*;
#(
  parameter logic [31:0]  USER_BASE      = USER_BASE_DEFAULT,
  parameter int unsigned  TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Mode,
  input  logic               ReadEnable,
  input  logic               WriteEnable,
  input  logic [1:0]         DataWidth,
  input  logic [DATA_W-1:0]  MemoryAddress,
  input  logic [DATA_W-1:0]  DataOut,
  output logic [DATA_W-1:0]  DataIn,
  output logic               Stall,
  output logic               Fault,
  output logic [1:0]         FaultCause,
  output logic               MemRequest,
  output logic               MemWrite,
  output logic [WADDR_W-1:0] MemAddress,
  output logic [LANES-1:0]   MemByteEnable,
  output logic [DATA_W-1:0]  MemWriteData,
  input  logic [DATA_W-1:0]  MemReadData,
  input  logic               MemValid
);

  state_e            state_q, state_d;
  cause_e            cause_q, cause_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              req_c;
  logic              align_bad_c;
  logic              priv_bad_c;
  logic              timeout_c;
  logic [DATA_W-1:0] rd_align_c;
  width_e            width_c;

  assign width_c     = width_e'(DataWidth);
  assign req_c       = ReadEnable | WriteEnable;
  assign align_bad_c = bad_width(width_c, MemoryAddress[1:0]);
  assign priv_bad_c  = Mode && (MemoryAddress < USER_BASE);

  // The core holds the request stable while stalled, so the live address
  // and width also steer the read data captured in WAIT.
  sol32_lane_align u_lane_align (
    .width_i (width_c),
    .addr_i  (MemoryAddress[1:0]),
    .wdata_i (DataOut),
    .rdata_i (MemReadData),
    .be_o    (MemByteEnable),
    .wdata_o (MemWriteData),
    .rdata_o (rd_align_c)
  );

  assign MemAddress = MemoryAddress[DATA_W-1:2];
  assign MemWrite   = WriteEnable;
  assign DataIn     = data_q;
  assign Fault      = (state_q == ST_FAULT);
  assign FaultCause = cause_q;

`ifdef SOL32_DPORT_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts WAIT cycles without completion; cleared when a request is issued.
  always_comb begin
    cnt_d = cnt_q;
    if (MemRequest) begin
      cnt_d = '0;
    end else if ((state_q == ST_WAIT) && !MemValid) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the last allowed WAIT cycle; MemValid takes priority there.
  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
  assign timeout_c      = 1'b0;
`endif

  // Next-state and combinational handshake outputs.
  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    data_d     = data_q;
    Stall      = 1'b0;
    MemRequest = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_c) begin
          Stall = 1'b1;
          if (ReadEnable && WriteEnable) begin
            cause_d = FC_CONFLICT;
            data_d  = '0;
            state_d = ST_FAULT;
          end else if (align_bad_c) begin
            cause_d = FC_ALIGN;
            data_d  = '0;
            state_d = ST_FAULT;
          end else if (priv_bad_c) begin
            cause_d = FC_PRIV;
            data_d  = '0;
            state_d = ST_FAULT;
          end else begin
            MemRequest = 1'b1;
            state_d    = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        Stall = 1'b1;
        if (MemValid) begin
          data_d  = WriteEnable ? '0 : rd_align_c;
          state_d = ST_DONE;
        end else if (timeout_c) begin
          cause_d = FC_TIMEOUT;
          data_d  = '0;
          state_d = ST_FAULT;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // No stall or memory strobe while held in reset.
    if (!Reset) begin
      Stall      = 1'b0;
      MemRequest = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      cause_q <= FC_ALIGN;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: doc/sol32_data_responder.md
Name: sol32_data_responder

Overview:
Memory-side responder for the sol32 core's data port. It accepts the core's load/store request (read/write enables, width, address, store data) and translates it into word-wide accesses on a variable-latency synchronous SRAM/bus port with byte enables. It returns lane-aligned load data to the core and stalls the core until the access completes. It also checks alignment and user-mode privilege and flags faults.

Parameters:
USER_BASE, 32'h0000_8000, lowest address user mode (Mode=1) may access; below is supervisor-only
TIMEOUT_CYCLES, 64, WAIT-state cycle limit before abort (only with SOL32_DPORT_TIMEOUT_EN)

Ports:
Clock  input  1  core clock, single clock domain
Reset  input  1  asynchronous, active-low reset
Mode  input  1  core privilege, 1=user, 0=supervisor
ReadEnable  input  1  core load request
WriteEnable  input  1  core store request
DataWidth  input  2  00=byte, 01=halfword, 10=word, 11=reserved
MemoryAddress  input  32  byte address from core
DataOut  input  32  store data from core, right-justified
DataIn  output  32  load data to core, zero-extended, right-justified
Stall  output  1  core must hold the instruction and request stable while high
Fault  output  1  one-cycle pulse, access rejected
FaultCause  output  2  0=align/width, 1=privilege, 2=timeout, 3=read+write conflict; valid with Fault
MemRequest  output  1  one-cycle access strobe to memory
MemWrite  output  1  1=write, qualified by MemRequest
MemAddress  output  30  word address = MemoryAddress[31:2]
MemByteEnable  output  4  active lanes
MemWriteData  output  32  lane-replicated store data
MemReadData  input  32  memory read word
MemValid  input  1  memory completion pulse, read data valid same cycle

Behaviour:
- Reset (Reset=0, async): state IDLE. DataIn=0, Fault=0, FaultCause=0, MemRequest=0, timeout counter=0. Stall is combinational and reads 0 with no request.
- States: IDLE, WAIT, DONE, FAULT.
- IDLE, no request: Stall=0.
- IDLE, request present (ReadEnable|WriteEnable): Stall=1.
  - Checks in priority order: both enables set -> cause 3; DataWidth=11, halfword with addr[0]=1, or word with addr[1:0]!=0 -> cause 0; Mode=1 and address<USER_BASE -> cause 1.
  - Any failed check -> FAULT. No MemRequest is issued.
  - Otherwise MemRequest=1 (combinational, this cycle only) -> WAIT.
- WAIT: Stall=1, MemRequest=0. On MemValid: register the aligned read data (zeros for writes) -> DONE.
- DONE: Stall=0. DataIn holds the captured data. The core retires this edge; -> IDLE.
- FAULT: Stall=0, Fault=1, FaultCause valid, DataIn=0 -> IDLE.
- DataIn holds its last value in IDLE/WAIT. It is defined only in the DONE cycle.
- Minimum latency: request to retire = 3 cycles (IDLE, WAIT with MemValid, DONE).
- Back-to-back: a new request in the cycle after DONE/FAULT is accepted normally.
- Byte enables:
  - byte: 4'b0001<<addr[1:0], write data {4{DataOut[7:0]}}
  - half: 4'b0011<<{addr[1],1'b0}, write data {2{DataOut[15:0]}}
  - word: 4'hF, write data DataOut
- Reads: MemReadData>>(addr[1:0]*8), masked to width, zero-extended.
- MemValid outside WAIT is ignored (stale completions after reset or timeout).
- Reset mid-WAIT aborts the transaction. Memory must tolerate an orphaned request.

Optional Feature:
SOL32_DPORT_TIMEOUT_EN
- Defined: counter clears on entry to WAIT and increments each WAIT cycle without MemValid. Reaching TIMEOUT_CYCLES -> FAULT with cause 2. MemValid on the same cycle as the limit wins (normal completion).
- Undefined: no counter; WAIT waits indefinitely. Cause 2 is never produced.

Decomposition:
- Package sol32_dport_pkg holds:
  - width enum (BYTE/HALF/WORD/RSVD)
  - state enum
  - fault-cause enum
  - default USER_BASE constant
- Sub-module sol32_lane_align (combinational): takes width and addr[1:0], produces byte enables, replicated write data and extracted read data. Reusable by the instruction-fetch side.

Test Plan:
- Supervisor word read addr 0x100, MemReadData=0xDEADBEEF, MemValid 1 cycle after request -> MemAddress=0x40, MemByteEnable=F; Stall high 2 cycles; DataIn=0xDEADBEEF in DONE.
- Byte write addr 0x8003, DataOut=0x000000A5 -> MemByteEnable=4'b1000, MemWriteData=0xA5A5A5A5, MemWrite=1.
- Halfword read addr 0x8002, MemReadData=0x1234ABCD -> DataIn=0x00001234. Halfword read addr 0x8001 -> Fault, FaultCause=0, no MemRequest.
- Mode=1 word read addr 0x4000 -> Fault with cause 1, DataIn=0, no MemRequest. Same access with Mode=0 -> completes.
- With SOL32_DPORT_TIMEOUT_EN and TIMEOUT_CYCLES=4, MemValid never asserted -> Fault with cause 2 after 4 WAIT cycles. A late MemValid afterwards is ignored and the next request proceeds.
- Reset pulsed low during WAIT -> Stall/MemRequest/Fault drop to 0 immediately, DataIn=0. After release, the next request completes normally.
